// File: rtl/serial_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deser_pkg
//  Description : Shared types and helpers for the serial frame deserialiser:
//                FSM state encoding, bit-counter width and parameter checks.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_deser_pkg;

    // Deserialiser control states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must be able to hold the values 0..FRAME_W
    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 1);
    endfunction

    // Frame must hold at least two bits and both fields must fit inside it
    function automatic bit params_legal(input int frame_w, input int n_w, input int d_w);
        return (frame_w >= 2) && (n_w >= 1) && (d_w >= 1) && ((n_w + d_w) <= frame_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/deser_shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : deser_shift_core
//  Description : Direction-selectable serial-in shift register with
//                synchronous clear. Also exposes the value it will hold after
//                the current edge so a completed frame can be captured on the
//                same edge that accepts its last bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module deser_shift_core #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] sr_next_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;
    logic [W-1:0] w_shl;
    logic [W-1:0] w_shr;

    // Both shift directions are formed; the parameter picks one
    assign w_shl = {sr_q[W-2:0], bit_i};
    assign w_shr = {bit_i, sr_q[W-1:1]};

    // Next register value: clear wins, otherwise shift on enable, else hold
    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = MSB_FIRST ? w_shl : w_shr;
        end
    end

    // Shift register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_next_o = sr_d;

endmodule
`default_nettype wire

// File: rtl/serial_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_deser
//  Description : Shifts a serial stream into FRAME_W-bit frames, holds each
//                completed frame for a valid/ready consumer, extracts the n/d
//                fields and flags frames dropped while the hold is occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_deser
    import serial_deser_pkg::*;
#(
    parameter  int FRAME_W   = 8,
    parameter  int N_W       = 4,
    parameter  int D_W       = 2,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int CNT_W     = cnt_width(FRAME_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               ser_in,
    input  logic               shen,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [FRAME_W-1:0] frame,
    output logic [N_W-1:0]     n,
    output logic [D_W-1:0]     d,
    output logic [CNT_W-1:0]   bit_cnt,
    output logic               busy,
    output logic               overrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    generate
        if (!params_legal(FRAME_W, N_W, D_W)) begin : g_param_check
            $error("serial_frame_deser: illegal FRAME_W/N_W/D_W combination");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic [FRAME_W-1:0] sr_next;
    logic               complete;
    logic               xfer;

    deser_shift_core #(
        .W         (FRAME_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (init),
        .en_i      (shen),
        .bit_i     (ser_in),
        .sr_next_o (sr_next)
    );

    // Next-state, bit counting, completion and hold/handshake update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        complete  = 1'b0;
        xfer      = valid_q & out_ready;

        if (init) begin
            state_d   = IDLE;
            cnt_d     = '0;
            frame_d   = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
            end
            if (shen) begin
                case (state_q)
                    IDLE: begin
                        state_d = SHIFT;
                        cnt_d   = CNT_W'(1);
                    end
                    SHIFT: begin
                        if (cnt_q == LAST_CNT) begin
                            complete = 1'b1;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
            // A frame finishing while the hold is still owned by the consumer is lost
            if (complete) begin
                if (!valid_q || xfer) begin
                    frame_d = sr_next;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // Control, counter and hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = valid_q;
    assign frame     = frame_q;
    assign n         = frame_q[N_W-1:0];
    assign d         = frame_q[N_W+D_W-1:N_W];
    assign bit_cnt   = cnt_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_deser
//  Description : Directed self-checking bench; an MSB-first and an LSB-first
//                instance share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_deser;

    logic       clk;
    logic       rst;
    logic       init;
    logic       ser_in;
    logic       shen;
    logic       out_ready;

    logic       m_valid, l_valid;
    logic [7:0] m_frame, l_frame;
    logic [3:0] m_n, l_n;
    logic [1:0] m_d, l_d;
    logic [3:0] m_cnt, l_cnt;
    logic       m_busy, l_busy;
    logic       m_ovr, l_ovr;

    int n_checks = 0;
    int n_errors = 0;

    serial_frame_deser #(.FRAME_W(8), .N_W(4), .D_W(2), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .init(init), .ser_in(ser_in), .shen(shen),
        .out_ready(out_ready), .out_valid(m_valid), .frame(m_frame), .n(m_n),
        .d(m_d), .bit_cnt(m_cnt), .busy(m_busy), .overrun(m_ovr)
    );

    serial_frame_deser #(.FRAME_W(8), .N_W(4), .D_W(2), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .init(init), .ser_in(ser_in), .shen(shen),
        .out_ready(out_ready), .out_valid(l_valid), .frame(l_frame), .n(l_n),
        .d(l_d), .bit_cnt(l_cnt), .busy(l_busy), .overrun(l_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit for the next rising edge
    task automatic send_bit(input logic b);
        @(negedge clk);
        shen   = 1'b1;
        ser_in = b;
    endtask

    // Eight bits, first bit = v[7], no gaps
    task automatic send_frame(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        shen = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; init = 1'b0; ser_in = 1'b0; shen = 1'b0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_frame", {24'd0, m_frame}, 32'd0);
        check_eq("rst_cnt",   {28'd0, m_cnt},   32'd0);
        check_eq("rst_busy",  {31'd0, m_busy},  32'd0);
        check_eq("rst_ovr",   {31'd0, m_ovr},   32'd0);
        rst = 1'b0;

        // Contiguous frame, consumer ready
        out_ready = 1'b1;
        send_frame(8'hB6);
        idle_cycle();
        check_eq("t1_valid",  {31'd0, m_valid}, 32'd1);
        check_eq("t1_frame",  {24'd0, m_frame}, 32'hB6);
        check_eq("t1_n",      {28'd0, m_n},     32'h6);
        check_eq("t1_d",      {30'd0, m_d},     32'h3);
        check_eq("t1_cnt",    {28'd0, m_cnt},   32'd0);
        check_eq("t1_busy",   {31'd0, m_busy},  32'd0);
        check_eq("t1l_frame", {24'd0, l_frame}, 32'h6D);
        check_eq("t1l_n",     {28'd0, l_n},     32'hD);
        check_eq("t1l_d",     {30'd0, l_d},     32'h2);
        @(negedge clk);
        check_eq("t1_drain",  {31'd0, m_valid}, 32'd0);

        // Overrun: consumer stalled across two frames
        out_ready = 1'b0;
        send_frame(8'hB6);
        idle_cycle();
        check_eq("t3_valid1", {31'd0, m_valid}, 32'd1);
        check_eq("t3_ovr1",   {31'd0, m_ovr},   32'd0);
        send_frame(8'h0F);
        idle_cycle();
        check_eq("t3_frame",  {24'd0, m_frame}, 32'hB6);
        check_eq("t3_ovr2",   {31'd0, m_ovr},   32'd1);
        check_eq("t3l_frame", {24'd0, l_frame}, 32'h6D);
        check_eq("t3l_ovr",   {31'd0, l_ovr},   32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t3_drain",  {31'd0, m_valid}, 32'd0);
        check_eq("t3_ovr3",   {31'd0, m_ovr},   32'd1);

        // Partial frame abandoned by init
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        idle_cycle();
        check_eq("t4_cnt3",   {28'd0, m_cnt},   32'd3);
        check_eq("t4_busy1",  {31'd0, m_busy},  32'd1);
        @(negedge clk);
        init = 1'b1;
        shen = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        init = 1'b0;
        shen = 1'b0;
        out_ready = 1'b0;
        check_eq("t4_cnt0",   {28'd0, m_cnt},   32'd0);
        check_eq("t4_busy0",  {31'd0, m_busy},  32'd0);
        check_eq("t4_ovr0",   {31'd0, m_ovr},   32'd0);
        send_frame(8'hA5);
        idle_cycle();
        check_eq("t4_valid",  {31'd0, m_valid}, 32'd1);
        check_eq("t4_frame",  {24'd0, m_frame}, 32'hA5);
        check_eq("t4l_frame", {24'd0, l_frame}, 32'hA5);
        check_eq("t4_ovr",    {31'd0, m_ovr},   32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t4_drain",  {31'd0, m_valid}, 32'd0);

        // Bits with two idle cycles between each
        pat = 8'hB6;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            idle_cycle();
            @(negedge clk);
            if (i > 0) check_eq("t5_cnt_gap", {28'd0, m_cnt}, 32'(8 - i));
        end
        check_eq("t5_valid",  {31'd0, m_valid}, 32'd1);
        check_eq("t5_frame",  {24'd0, m_frame}, 32'hB6);
        check_eq("t5l_frame", {24'd0, l_frame}, 32'h6D);

        // Asynchronous reset mid-frame with a frame still held
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        idle_cycle();
        check_eq("t6_cnt5",   {28'd0, m_cnt},   32'd5);
        check_eq("t6_held",   {31'd0, m_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_valid",  {31'd0, m_valid}, 32'd0);
        check_eq("t6_frame",  {24'd0, m_frame}, 32'd0);
        check_eq("t6_cnt",    {28'd0, m_cnt},   32'd0);
        check_eq("t6_busy",   {31'd0, m_busy},  32'd0);
        check_eq("t6_nd",     {26'd0, m_n, m_d}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'hB6);
        idle_cycle();
        check_eq("t6_frame2", {24'd0, m_frame}, 32'hB6);
        check_eq("t6_valid2", {31'd0, m_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Back-to-back frames, transfer on the completion edge of the second
        send_frame(8'h0F);
        pat = 8'hB6;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        @(negedge clk);
        shen = 1'b1;
        ser_in = pat[0];
        out_ready = 1'b1;
        @(negedge clk);
        shen = 1'b0;
        out_ready = 1'b0;
        check_eq("t7_valid",  {31'd0, m_valid}, 32'd1);
        check_eq("t7_frame",  {24'd0, m_frame}, 32'hB6);
        check_eq("t7_ovr",    {31'd0, m_ovr},   32'd0);
        check_eq("t7l_frame", {24'd0, l_frame}, 32'h6D);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t7_drain",  {31'd0, m_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
